// File: rtl/pipe_fetch_unit_if.sv
// Instruction-memory fetch channel between the fetch unit and the memory.
// The fetch unit holds imem_req high with imem_addr stable until memory
// answers with imem_ack and the instruction word on imem_rdata.
interface pipe_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pipe_fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register.
// A request is held on the memory channel until it is acknowledged. If ID
// stalls (wpcir=0) when the word arrives, the word is parked in a hold buffer
// and the request is dropped until ID can accept it. A branch/jump that
// leaves ID before its delay slot has been fetched parks its target in a
// redirect register, which is used for the fetch after the delay slot.
module pipe_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     wpcir,
  input  logic [1:0]               pcsource,
  input  logic [31:0]              bpc,
  input  logic [31:0]              da,
  input  logic [31:0]              jpc,
  pipe_fetch_unit_if.master        imem,
  output logic [31:0]              pc,
  output logic [31:0]              dinst,
  output logic [31:0]              dpc4,
  output logic                     dvalid,
  output logic [5:0]               op,
  output logic [5:0]               func
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_dinst;
  logic [31:0] r_dpc4;
  logic        r_dvalid;
  logic        r_redir_v;
  logic [31:0] r_redir_pc;
  logic [31:0] r_hold;
  logic        r_req;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_dinst_nxt;
  logic [31:0] w_dpc4_nxt;
  logic        w_dvalid_nxt;
  logic        w_redir_v_nxt;
  logic [31:0] w_redir_pc_nxt;
  logic [31:0] w_hold_nxt;
  logic        w_req_nxt;

  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic        w_br_v;
  logic [31:0] w_npc;
  logic        w_ack;
  logic        w_xfer;
  logic [31:0] w_word;

  // r_req is zero for the cycle right after reset, so an ack seen then is ignored.
  assign w_pc4  = r_pc + 32'd4;
  assign w_ack  = (r_state == ST_FETCH) && r_req && imem.imem_ack;
  assign w_xfer = wpcir && (w_ack || (r_state == ST_HOLD));
  assign w_word = (r_state == ST_HOLD) ? r_hold : imem.imem_rdata;
  // A bubble in ID decodes as sll, so pcsource only counts for a real instruction.
  assign w_br_v = r_dvalid && (pcsource != 2'b00);
  assign w_npc  = r_redir_v ? r_redir_pc : (w_br_v ? w_target : w_pc4);

  // Target selection from the ID-stage decode.
  always_comb begin
    w_target = w_pc4;
    case (pcsource)
      2'b00:   w_target = w_pc4;
      2'b01:   w_target = bpc;
      2'b10:   w_target = da;
      2'b11:   w_target = jpc;
      default: w_target = w_pc4;
    endcase
  end

  // Next-state and IF/ID / PC / redirect update decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_dinst_nxt    = r_dinst;
    w_dpc4_nxt     = r_dpc4;
    w_dvalid_nxt   = r_dvalid;
    w_redir_v_nxt  = r_redir_v;
    w_redir_pc_nxt = r_redir_pc;
    w_hold_nxt     = r_hold;

    case (r_state)
      ST_FETCH: begin
        if (w_ack && !wpcir) begin
          w_hold_nxt  = imem.imem_rdata;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (wpcir) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase

    if (w_xfer) begin
      // The delay-slot word (or any next word) enters IF/ID; a pending or
      // same-cycle redirect steers the following fetch.
      w_dinst_nxt   = w_word;
      w_dpc4_nxt    = w_pc4;
      w_dvalid_nxt  = 1'b1;
      w_pc_nxt      = w_npc;
      w_redir_v_nxt = 1'b0;
    end else if (wpcir) begin
      // ID advances but nothing was fetched: insert a bubble, and remember any
      // branch target so the still-pending delay slot is not lost.
      w_dinst_nxt  = 32'h0000_0000;
      w_dpc4_nxt   = 32'h0000_0000;
      w_dvalid_nxt = 1'b0;
      if (w_br_v) begin
        w_redir_v_nxt  = 1'b1;
        w_redir_pc_nxt = w_target;
      end else begin
        w_redir_v_nxt  = r_redir_v;
      end
    end else begin
      w_dvalid_nxt = r_dvalid;
    end

    w_req_nxt = (w_state_nxt == ST_FETCH);
  end

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers; reset discards any outstanding request and held word.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pc       <= RESET_PC;
      r_dinst    <= 32'h0000_0000;
      r_dpc4     <= 32'h0000_0000;
      r_dvalid   <= 1'b0;
      r_redir_v  <= 1'b0;
      r_redir_pc <= 32'h0000_0000;
      r_hold     <= 32'h0000_0000;
      r_req      <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_dinst    <= w_dinst_nxt;
      r_dpc4     <= w_dpc4_nxt;
      r_dvalid   <= w_dvalid_nxt;
      r_redir_v  <= w_redir_v_nxt;
      r_redir_pc <= w_redir_pc_nxt;
      r_hold     <= w_hold_nxt;
      r_req      <= w_req_nxt;
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign pc             = r_pc;
  assign dinst          = r_dinst;
  assign dpc4           = r_dpc4;
  assign dvalid         = r_dvalid;
  assign op             = r_dinst[31:26];
  assign func           = r_dinst[5:0];

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed bench for pipe_fetch_unit: sequential fetch, ID stall with HOLD,
// reset during HOLD, branch with and without same-cycle ack, and PC wrap.
module tb_pipe_fetch_unit;

  logic        clock;
  logic        resetn;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] da;
  logic [31:0] jpc;
  logic [31:0] pc;
  logic [31:0] dinst;
  logic [31:0] dpc4;
  logic        dvalid;
  logic [5:0]  op;
  logic [5:0]  func;

  int n_checks;
  int n_errors;

  pipe_fetch_unit_if u_if ();

  pipe_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clock    (clock),
    .resetn   (resetn),
    .wpcir    (wpcir),
    .pcsource (pcsource),
    .bpc      (bpc),
    .da       (da),
    .jpc      (jpc),
    .imem     (u_if),
    .pc       (pc),
    .dinst    (dinst),
    .dpc4     (dpc4),
    .dvalid   (dvalid),
    .op       (op),
    .func     (func)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Instruction word stored at a given address in the bench's memory image.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h2008_0001 + (a >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rd);
    u_if.imem_ack   = ack;
    u_if.imem_rdata = rd;
  endtask

  initial begin
    logic [31:0] a;
    n_checks = 0;
    n_errors = 0;
    resetn   = 1'b0;
    wpcir    = 1'b1;
    pcsource = 2'b00;
    bpc      = 32'h0000_0000;
    da       = 32'h0000_0000;
    jpc      = 32'h0000_0000;
    drive(1'b0, 32'h0000_0000);

    // Reset state.
    #12;
    check("rst_req",    32'(u_if.imem_req), 32'd0);
    check("rst_pc",     pc, 32'h0000_0000);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_dinst",  dinst, 32'h0000_0000);
    resetn = 1'b1;
    tick();
    check("post_rst_req",  32'(u_if.imem_req), 32'd1);
    check("post_rst_addr", u_if.imem_addr, 32'h0000_0000);

    // Sequential fetch, ack every cycle.
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      drive(1'b1, word_at(a));
      tick();
      check("seq_dinst",  dinst, word_at(a));
      check("seq_dpc4",   dpc4, a + 32'd4);
      check("seq_dvalid", 32'(dvalid), 32'd1);
      check("seq_addr",   u_if.imem_addr, a + 32'd4);
    end
    check("seq_op",   32'(op), 32'h0000_0008);
    check("seq_func", 32'(func), 32'h0000_0004);

    // ID stall when the word at 0x10 arrives: HOLD for three cycles.
    wpcir = 1'b0;
    drive(1'b1, word_at(32'h10));
    tick();
    check("hold_req",   32'(u_if.imem_req), 32'd0);
    check("hold_dinst", dinst, word_at(32'h0C));
    check("hold_pc",    pc, 32'h0000_0010);
    drive(1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold2_req",   32'(u_if.imem_req), 32'd0);
      check("hold2_dinst", dinst, word_at(32'h0C));
    end
    wpcir = 1'b1;
    drive(1'b0, 32'h0000_0000);
    tick();
    check("release_dinst", dinst, word_at(32'h10));
    check("release_dpc4",  dpc4, 32'h0000_0014);
    check("release_req",   32'(u_if.imem_req), 32'd1);
    check("release_addr",  u_if.imem_addr, 32'h0000_0014);

    // Advance to 0x24 and stall there, then reset while in HOLD.
    for (int i = 0; i < 4; i++) begin
      a = 32'h14 + 32'(i * 4);
      drive(1'b1, word_at(a));
      tick();
    end
    check("pre_hold_dinst", dinst, word_at(32'h20));
    wpcir = 1'b0;
    drive(1'b1, word_at(32'h24));
    tick();
    check("hold24_pc",  pc, 32'h0000_0024);
    check("hold24_req", 32'(u_if.imem_req), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    check("async_pc",     pc, 32'h0000_0000);
    check("async_dinst",  dinst, 32'h0000_0000);
    check("async_dpc4",   dpc4, 32'h0000_0000);
    check("async_dvalid", 32'(dvalid), 32'd0);
    check("async_req",    32'(u_if.imem_req), 32'd0);
    #1;
    resetn = 1'b1;
    wpcir  = 1'b1;
    drive(1'b0, 32'h0000_0000);
    tick();
    check("rst2_req",    32'(u_if.imem_req), 32'd1);
    check("rst2_addr",   u_if.imem_addr, 32'h0000_0000);
    check("rst2_dvalid", 32'(dvalid), 32'd0);
    check("rst2_dinst",  dinst, 32'h0000_0000);

    // beq in ID with the delay slot acknowledged the same cycle.
    drive(1'b1, word_at(32'h00));
    tick();
    check("rst2_first_dinst", dinst, word_at(32'h00));
    drive(1'b1, word_at(32'h04));
    tick();
    pcsource = 2'b01;
    bpc      = 32'h0000_0040;
    drive(1'b1, word_at(32'h08));
    tick();
    check("beq_dinst", dinst, word_at(32'h08));
    check("beq_dpc4",  dpc4, 32'h0000_000C);
    check("beq_addr",  u_if.imem_addr, 32'h0000_0040);

    // jr in ID with no ack: bubble, redirect remembered for after the slot.
    pcsource = 2'b00;
    drive(1'b1, word_at(32'h40));
    tick();
    check("tgt_dinst", dinst, word_at(32'h40));
    pcsource = 2'b10;
    da       = 32'h0000_0080;
    drive(1'b0, 32'h0000_0000);
    tick();
    check("jr_bubble_dvalid", 32'(dvalid), 32'd0);
    check("jr_bubble_dinst",  dinst, 32'h0000_0000);
    check("jr_bubble_addr",   u_if.imem_addr, 32'h0000_0044);
    pcsource = 2'b11;
    jpc      = 32'h0000_BAD0;
    drive(1'b1, word_at(32'h44));
    tick();
    check("jr_slot_dinst", dinst, word_at(32'h44));
    check("jr_slot_dpc4",  dpc4, 32'h0000_0048);
    check("jr_redir_addr", u_if.imem_addr, 32'h0000_0080);

    // Jump to the top of the address space and check pc+4 wrap.
    pcsource = 2'b11;
    jpc      = 32'hFFFF_FFFC;
    drive(1'b1, word_at(32'h80));
    tick();
    check("j_dinst", dinst, word_at(32'h80));
    check("j_addr",  u_if.imem_addr, 32'hFFFF_FFFC);
    pcsource = 2'b00;
    drive(1'b1, 32'h8C43_002A);
    tick();
    check("wrap_dinst", dinst, 32'h8C43_002A);
    check("wrap_dpc4",  dpc4, 32'h0000_0000);
    check("wrap_addr",  u_if.imem_addr, 32'h0000_0000);
    check("wrap_op",    32'(op), 32'h0000_0023);
    check("wrap_func",  32'(func), 32'h0000_002A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
